// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: shared HI/LO op, unit op and FSM encodings plus the watchdog limit
package muldiv_ctrl_pkg;
  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_MULT  = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_DIV   = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [1:0] MD_MULTU = 2'd0;
  localparam logic [1:0] MD_MULT  = 2'd1;
  localparam logic [1:0] MD_DIVU  = 2'd2;
  localparam logic [1:0] MD_DIV   = 2'd3;
  localparam logic [4:0] WD_LIMIT = 5'd20;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LAUNCH = 2'd1, ST_WAIT = 2'd2} state_t;
endpackage

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EX-stage issue/stall control for the HI/LO multiply-divide unit with watchdog.
// Define MULDIV_STALL_CNT_EN to add a saturating stall-cycle counter on stall_cnt.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [3:0]  ex_op,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic        flush,
  output logic        md_start,
  output logic [1:0]  md_op,
  output logic [31:0] md_srcA,
  output logic [31:0] md_srcB,
  output logic        md_wr,
  output logic        md_wr_hi,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        md_err,
  output logic [31:0] stall_cnt
);
  state_t state;
  logic [4:0] wd;
  logic go, idle, is_md, is_mf, is_mt;
  assign go    = ~reset & ex_valid & ~flush;
  assign idle  = state == ST_IDLE;
  assign is_md = ex_op inside {OP_MULTU, OP_MULT, OP_DIVU, OP_DIV};
  assign is_mf = ex_op inside {OP_MFHI, OP_MFLO};
  assign is_mt = ex_op inside {OP_MTHI, OP_MTLO};
  always_comb begin
    stall    = go & (is_md | is_mf | is_mt) & ~idle;
    md_start = go & is_md & idle;
    md_wr    = go & is_mt & idle;
    rd_valid = go & is_mf & idle;
    md_op    = md_start ? 2'(ex_op - OP_MULTU) : MD_MULTU;
    md_srcA  = (md_start | md_wr) ? ex_rs : '0;
    md_srcB  = md_start ? ex_rt : '0;
    md_wr_hi = md_wr & (ex_op == OP_MTHI);
    rd_data  = !rd_valid ? '0 : ex_op == OP_MFHI ? md_hi : md_lo;
  end
  // flush never aborts an in-flight op: the FSM follows md_busy regardless
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      wd     <= '0;
      md_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (md_start) state <= ST_LAUNCH;
        ST_LAUNCH: begin
          state <= md_busy ? ST_WAIT : ST_IDLE;
          wd    <= '0;
        end
        ST_WAIT: begin
          if (!md_busy) state <= ST_IDLE;
          else if (wd == 5'(WD_LIMIT - 5'd1)) begin
            md_err <= 1'b1;
            state  <= ST_IDLE;
          end else wd <= wd + 5'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`ifdef MULDIV_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed plus random checks of muldiv_ctrl against a behavioural HI/LO unit model
module tb_muldiv_ctrl;
  logic clk = 1'b0;
  logic reset, ex_valid, flush, md_busy, md_start, md_wr, md_wr_hi, stall, rd_valid, md_err;
  logic [3:0] ex_op;
  logic [1:0] md_op;
  logic [31:0] ex_rs, ex_rt, md_srcA, md_srcB, md_hi, md_lo, rd_data, stall_cnt;
  logic [31:0] exp_hi, exp_lo;
  logic [63:0] res;
  int npass = 0, ntot = 0, lat = 1, bcnt = 0;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .flush(flush), .md_start(md_start), .md_op(md_op), .md_srcA(md_srcA), .md_srcB(md_srcB),
    .md_wr(md_wr), .md_wr_hi(md_wr_hi), .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo),
    .stall(stall), .rd_data(rd_data), .rd_valid(rd_valid), .md_err(md_err), .stall_cnt(stall_cnt)
  );

  function automatic logic [63:0] calc(int op, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      1: return {32'd0, a} * {32'd0, b};
      2: return sa * sb;
      3: return (b == 0) ? 64'd0 : {a % b, a / b};
      default: return (b == 0) ? 64'd0 : {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    endcase
  endfunction

  assign md_busy = bcnt != 0;
  always @(posedge clk) begin
    if (reset) begin
      bcnt  <= 0;
      md_hi <= '0;
      md_lo <= '0;
    end else begin
      if (md_start) begin
        bcnt <= lat;
        res  <= calc(int'(md_op) + 1, md_srcA, md_srcB);
      end else if (bcnt != 0) begin
        bcnt <= bcnt - 1;
        if (bcnt == 1) begin
          md_hi <= res[63:32];
          md_lo <= res[31:0];
        end
      end
      if (md_wr) begin
        if (md_wr_hi) md_hi <= md_srcA;
        else md_lo <= md_srcA;
      end
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    ntot++;
    assert (obs === expv) npass++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(logic v, logic [3:0] op, logic [31:0] rs, logic [31:0] rt, logic fl);
    ex_valid = v;
    ex_op = op;
    ex_rs = rs;
    ex_rt = rt;
    flush = fl;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drv(0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    drv(0, 0, 0, 0, 0);
    exp_hi = '0;
    exp_lo = '0;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_start"}, 32'(md_start), 0);
    chk({tag, "_op"}, 32'(md_op), 0);
    chk({tag, "_srcA"}, md_srcA, 0);
    chk({tag, "_srcB"}, md_srcB, 0);
    chk({tag, "_wr"}, 32'(md_wr), 0);
    chk({tag, "_wrhi"}, 32'(md_wr_hi), 0);
    chk({tag, "_stall"}, 32'(stall), 0);
    chk({tag, "_rdv"}, 32'(rd_valid), 0);
    chk({tag, "_rd"}, rd_data, 0);
    chk({tag, "_err"}, 32'(md_err), 0);
    chk({tag, "_scnt"}, stall_cnt, 0);
  endtask

  task automatic issue(logic [3:0] op, logic [31:0] a, logic [31:0] b, int l);
    lat = l;
    drv(1, op, a, b, 0);
    chk("iss_start", 32'(md_start), 1);
    chk("iss_op", 32'(md_op), 32'(op) - 1);
    chk("iss_srcA", md_srcA, a);
    chk("iss_srcB", md_srcB, b);
    chk("iss_stall", 32'(stall), 0);
    chk("iss_wr", 32'(md_wr), 0);
    {exp_hi, exp_lo} = calc(int'(op), a, b);
    step();
  endtask

  task automatic wait_stall(int expn, string tag);
    int n;
    n = 0;
    drv(1, 6, 0, 0, 0);
    while (stall === 1'b1 && n < 60) begin
      n++;
      step();
      drv(1, 6, 0, 0, 0);
    end
    chk(tag, 32'(n), 32'(expn));
  endtask

  task automatic run_md(logic [3:0] op, logic [31:0] a, logic [31:0] b, int l);
    issue(op, a, b, l);
    wait_stall(l + 1, "stall_len");
    chk("rd_lo", rd_data, exp_lo);
    chk("rdv_lo", 32'(rd_valid), 1);
    drv(1, 5, 0, 0, 0);
    chk("rd_hi", rd_data, exp_hi);
    step();
  endtask

  initial begin
    int n, op, l;
    logic [31:0] a, b;
    reset = 1'b1;
    drv(0, 0, 0, 0, 0);
    step();
    do_reset();
    check_zero("rst");

    run_md(1, 32'd5, 32'd6, 6);
`ifdef MULDIV_STALL_CNT_EN
    chk("scnt7", stall_cnt, 7);
`else
    chk("scnt_off", stall_cnt, 0);
`endif
    issue(2, 32'd9, 32'd9, 8);
    drv(0, 0, 0, 0, 0);
    step();
    do_reset();
    check_zero("rstwait");
    drv(1, 5, 0, 0, 0);
    chk("rstwait_idle", 32'(stall), 0);
    chk("rstwait_rdv", 32'(rd_valid), 1);
    chk("rstwait_hi", rd_data, 0);
    step();

    run_md(2, 32'hFFFF_FFFE, 32'd3, 4);
    drv(1, 6, 0, 0, 0);
    chk("mult_lo_const", rd_data, 32'hFFFF_FFFA);
    step();

    issue(3, 32'd100, 32'd7, 10);
    lat = 3;
    n = 0;
    drv(1, 1, 32'd11, 32'd13, 0);
    while (stall === 1'b1 && n < 60) begin
      n++;
      step();
      drv(1, 1, 32'd11, 32'd13, 0);
    end
    chk("b2b_stall", 32'(n), 11);
    chk("b2b_start", 32'(md_start), 1);
    chk("b2b_srcA", md_srcA, 32'd11);
    chk("divu_hi", md_hi, 32'd2);
    chk("divu_lo", md_lo, 32'd14);
    {exp_hi, exp_lo} = calc(1, 32'd11, 32'd13);
    step();
    wait_stall(4, "b2b_multu_stall");
    chk("multu_lo_const", rd_data, 32'd143);
    step();

    drv(1, 7, 32'h1234_5678, 32'hAAAA_AAAA, 0);
    chk("mthi_wr", 32'(md_wr), 1);
    chk("mthi_wrhi", 32'(md_wr_hi), 1);
    chk("mthi_srcA", md_srcA, 32'h1234_5678);
    chk("mthi_srcB", md_srcB, 0);
    chk("mthi_start", 32'(md_start), 0);
    chk("mthi_stall", 32'(stall), 0);
    step();
    drv(1, 8, 32'hCAFE_BABE, 0, 0);
    chk("mtlo_wr", 32'(md_wr), 1);
    chk("mtlo_wrhi", 32'(md_wr_hi), 0);
    step();
    drv(1, 5, 0, 0, 0);
    chk("mfhi_after_mthi", rd_data, 32'h1234_5678);
    drv(1, 6, 0, 0, 0);
    chk("mflo_after_mtlo", rd_data, 32'hCAFE_BABE);
    exp_hi = 32'h1234_5678;
    exp_lo = 32'hCAFE_BABE;
    step();

    drv(1, 2, 32'd3, 32'd4, 1);
    chk("fl_start", 32'(md_start), 0);
    chk("fl_srcA", md_srcA, 0);
    step();
    drv(1, 7, 32'd1, 0, 1);
    chk("fl_wr", 32'(md_wr), 0);
    drv(1, 6, 0, 0, 0);
    chk("fl_idle", 32'(stall), 0);
    chk("fl_idle_rd", rd_data, 32'hCAFE_BABE);
    step();
    issue(1, 32'd7, 32'd8, 6);
    drv(1, 6, 0, 0, 0);
    chk("fw_launch", 32'(stall), 1);
    step();
    drv(1, 6, 0, 0, 1);
    chk("fw_stall", 32'(stall), 0);
    chk("fw_rdv", 32'(rd_valid), 0);
    step();
    wait_stall(5, "fw_persist");
    chk("fw_lo", rd_data, 32'd56);
    step();

    for (int i = 0; i < 16; i++) begin
      op = $urandom_range(1, 8);
      a = $urandom;
      b = $urandom;
      if (b == 0) b = 1;
      l = $urandom_range(1, 8);
      if (op <= 4) run_md(4'(op), a, b, l);
      else if (op >= 7) begin
        drv(1, 4'(op), a, b, 0);
        chk("r_wr", 32'(md_wr), 1);
        chk("r_wrhi", 32'(md_wr_hi), 32'(op == 7));
        chk("r_srcA", md_srcA, a);
        if (op == 7) exp_hi = a;
        else exp_lo = a;
        step();
      end else begin
        drv(1, 4'(op), a, b, 0);
        chk("r_rdv", 32'(rd_valid), 1);
        chk("r_rd", rd_data, op == 5 ? exp_hi : exp_lo);
        step();
      end
    end

    drv(0, 0, 0, 0, 0);
    chk("wd_err0", 32'(md_err), 0);
    issue(2, 32'd77, 32'd88, 25);
    wait_stall(21, "wd_stall");
    chk("wd_err", 32'(md_err), 1);
    drv(0, 0, 0, 0, 0);
    repeat (6) step();
    chk("wd_err_hold", 32'(md_err), 1);
    drv(1, 6, 0, 0, 0);
    chk("wd_late_lo", rd_data, exp_lo);
    step();
    do_reset();
    chk("wd_err_rst", 32'(md_err), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
